// File: rtl/sel_accum_dump_if.sv
// sel_accum_dump_if: sample/operand inputs and window dump outputs of sel_accum_dump
interface sel_accum_dump_if #(
  parameter int DATA_W = 3,
  parameter int ACC_W  = 6,
  parameter int CNT_W  = 3
);
  logic              valid;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic [1:0]        sel;
  logic              clear;
  logic [ACC_W-1:0]  dump_data;
  logic              dump_valid;
  logic              dump_ovf;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  count;
  modport master (
    output valid, data1, data2, sel, clear,
    input  dump_data, dump_valid, dump_ovf, acc, count
  );
  modport slave (
    input  valid, data1, data2, sel, clear,
    output dump_data, dump_valid, dump_ovf, acc, count
  );
endinterface

// File: rtl/sel_accum_dump.sv
// sel_accum_dump: operand select + windowed accumulator with dump pulse and overflow flag
// SEL_ACCUM_SATURATE_EN clamps the running sum at all-ones after a carry; default wraps.
module sel_accum_dump #(
  parameter int DATA_W   = 3,
  parameter int ACC_W    = 6,
  parameter int DUMP_LEN = 4
) (
  input logic clk,
  input logic i_rst,
  sel_accum_dump_if.slave bus
);
  localparam int CNT_W = $clog2(DUMP_LEN) + 1;
  logic [ACC_W-1:0] op, acc, nxt, dump_data, sel_op;
  logic [ACC_W:0]   sum;
  logic [CNT_W-1:0] count;
  logic             v1, ovf, carry, dump_valid, dump_ovf, last;
  assign sel_op = bus.sel == 2'b11 ? ACC_W'(bus.data1) + ACC_W'(bus.data2) :
                  bus.sel == 2'b01 ? ACC_W'(bus.data1) :
                  bus.sel == 2'b10 ? ACC_W'(bus.data2) : '0;
  assign sum   = {1'b0, acc} + {1'b0, op};
  assign carry = sum[ACC_W];
  assign last  = count == CNT_W'(DUMP_LEN - 1);
`ifdef SEL_ACCUM_SATURATE_EN
  assign nxt = (ovf | carry) ? '1 : sum[ACC_W-1:0];
`else
  assign nxt = sum[ACC_W-1:0];
`endif
  always_ff @(posedge clk) begin
    if (i_rst) begin
      op         <= '0;
      v1         <= 1'b0;
      acc        <= '0;
      count      <= '0;
      ovf        <= 1'b0;
      dump_data  <= '0;
      dump_valid <= 1'b0;
      dump_ovf   <= 1'b0;
    end else if (bus.clear) begin
      v1         <= 1'b0;
      acc        <= '0;
      count      <= '0;
      ovf        <= 1'b0;
      dump_valid <= 1'b0;
    end else begin
      v1         <= bus.valid;
      dump_valid <= 1'b0;
      if (bus.valid) op <= sel_op;
      if (v1 && last) begin
        dump_data  <= nxt;
        dump_ovf   <= ovf | carry;
        dump_valid <= 1'b1;
        acc        <= '0;
        count      <= '0;
        ovf        <= 1'b0;
      end else if (v1) begin
        acc   <= nxt;
        count <= count + 1'b1;
        ovf   <= ovf | carry;
      end
    end
  end
  assign bus.dump_data  = dump_data;
  assign bus.dump_valid = dump_valid;
  assign bus.dump_ovf   = dump_ovf;
  assign bus.acc        = acc;
  assign bus.count      = count;
endmodule

// File: tb/tb_sel_accum_dump.sv
// tb_sel_accum_dump: drives DUMP_LEN=4 and DUMP_LEN=8 instances with shared stimulus
// and compares both against a window-sum reference model.
module tb_sel_accum_dump;
  logic clk = 1'b0;
  logic rst;
  int total = 0, bad = 0;
  int lens[2] = '{4, 8};
  int tsum[2], cnt[2], pval[2], edata[2];
  bit pv[2], eovf[2], evalid[2];
  always #5 clk = ~clk;
  sel_accum_dump_if #(.DATA_W(3), .ACC_W(6), .CNT_W(3)) bus4 ();
  sel_accum_dump_if #(.DATA_W(3), .ACC_W(6), .CNT_W(4)) bus8 ();
  sel_accum_dump #(.DATA_W(3), .ACC_W(6), .DUMP_LEN(4)) dut4 (.clk(clk), .i_rst(rst), .bus(bus4));
  sel_accum_dump #(.DATA_W(3), .ACC_W(6), .DUMP_LEN(8)) dut8 (.clk(clk), .i_rst(rst), .bus(bus8));
  task automatic check(string tag, int obs, int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask
  function automatic int disp(int t);
`ifdef SEL_ACCUM_SATURATE_EN
    return t > 63 ? 63 : t;
`else
    return t % 64;
`endif
  endfunction
  task automatic model(bit v, int a, int b, int s, bit c, bit r);
    int o;
    o = s == 0 ? 0 : s == 1 ? a : s == 2 ? b : a + b;
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        tsum[k] = 0; cnt[k] = 0; pv[k] = 0; edata[k] = 0; eovf[k] = 0; evalid[k] = 0;
      end else if (c) begin
        tsum[k] = 0; cnt[k] = 0; pv[k] = 0; evalid[k] = 0;
      end else begin
        evalid[k] = 0;
        if (pv[k]) begin
          tsum[k] += pval[k];
          cnt[k]++;
          if (cnt[k] == lens[k]) begin
            edata[k] = disp(tsum[k]);
            eovf[k] = tsum[k] > 63;
            evalid[k] = 1;
            tsum[k] = 0;
            cnt[k] = 0;
          end
        end
        pv[k] = v;
        if (v) pval[k] = o;
      end
    end
  endtask
  task automatic step(bit v, int a, int b, int s, bit c, bit r);
    logic [2:0] a3, b3;
    a3 = a[2:0];
    b3 = b[2:0];
    bus4.valid = v; bus4.data1 = a3; bus4.data2 = b3; bus4.sel = s[1:0]; bus4.clear = c;
    bus8.valid = v; bus8.data1 = a3; bus8.data2 = b3; bus8.sel = s[1:0]; bus8.clear = c;
    rst = r;
    @(posedge clk);
    model(v, a, b, s, c, r);
    #1;
    check("acc4", bus4.acc, disp(tsum[0]));
    check("cnt4", bus4.count, cnt[0]);
    check("vld4", bus4.dump_valid, evalid[0]);
    check("dat4", bus4.dump_data, edata[0]);
    check("ovf4", bus4.dump_ovf, eovf[0]);
    check("acc8", bus8.acc, disp(tsum[1]));
    check("cnt8", bus8.count, cnt[1]);
    check("vld8", bus8.dump_valid, evalid[1]);
    check("dat8", bus8.dump_data, edata[1]);
    check("ovf8", bus8.dump_ovf, eovf[1]);
  endtask
  initial begin
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    check("rst_data", bus4.dump_data, 0);
    for (int i = 0; i < 6; i++) step(1, $urandom_range(7), $urandom_range(7), $urandom_range(3), 0, 0);
    for (int i = 0; i < 3; i++) step(1, 7, 7, 3, 0, 1);
    check("t1_acc", bus4.acc, 0);
    check("t1_ovf", bus8.dump_ovf, 0);
    for (int i = 0; i < 4; i++) step(1, 3, 2, 3, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("t2_valid", bus4.dump_valid, 1);
    check("t2_data", bus4.dump_data, 20);
    step(0, 0, 0, 0, 0, 0);
    check("t2_pulse", bus4.dump_valid, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 7, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0);
    end
    check("t3_data", bus4.dump_data, 28);
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 7, 7, 3, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("t4_valid", bus8.dump_valid, 1);
`ifdef SEL_ACCUM_SATURATE_EN
    check("t4_data", bus8.dump_data, 63);
`else
    check("t4_data", bus8.dump_data, 48);
`endif
    check("t4_ovf", bus8.dump_ovf, 1);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("t4_clean_data", bus8.dump_data, 8);
    check("t4_clean_ovf", bus8.dump_ovf, 0);
    check("t6_data", bus4.dump_data, 4);
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 5, 2, 0, 0);
    step(1, 0, 5, 2, 0, 0);
    step(1, 0, 5, 2, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    check("t5_acc", bus4.acc, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 5, 2, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("t5_data", bus4.dump_data, 20);
    for (int i = 0; i < 4; i++) step(1, 0, 5, 2, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    check("t5_nodump", bus4.dump_valid, 0);
    check("t5_hold", bus4.dump_data, 20);
    for (int i = 0; i < 400; i++)
      step($urandom_range(9) < 7, $urandom_range(7), $urandom_range(7), $urandom_range(3),
           $urandom_range(19) == 0, $urandom_range(49) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
